// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the 1011 serial generator and its match counter.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int          PAT_W     = 4;
    localparam logic [3:0]  MATCH_PAT = 4'b1011;

endpackage

// File: rtl/seq_match_counter.sv
// Watches a serial line for overlapping 1011 patterns; strobes and counts each one (saturating).
module seq_match_counter
    import seq_gen_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             serial,
    input  logic             clr,
    output logic             pulse,
    output logic [CNT_W-1:0] count
);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] next_hist;
    logic             hit;

    assign next_hist = {hist[PAT_W-2:0], serial};
    assign hit       = (next_hist == MATCH_PAT);

    // Clear takes priority over the increment but leaves the history alone,
    // so a pattern straddling the clear is still seen.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist  <= '0;
            pulse <= 1'b0;
            count <= '0;
        end else begin
            hist  <= next_hist;
            pulse <= hit;
            if (clr) begin
                count <= '0;
            end else if (hit && (count != '1)) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_gen_1011.sv
// Serialises parallel words MSB-first onto one line with optional zero gaps,
// and counts 1011 occurrences on that same line.
module seq_gen_1011
    import seq_gen_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LEN_W  = $clog2(DATA_W + 1),
    parameter int GAP    = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [LEN_W-1:0]  in_len,
    output logic              out,
    output logic              out_valid,
    output logic              busy,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              match_pulse,
    output state_t            state_dbg
);

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    state_t             state;
    logic [DATA_W-1:0]  sr;
    logic [LEN_W-1:0]   bits_left;
    logic [GAP_W-1:0]   gap_cnt;

    logic [LEN_W-1:0]   len_eff;
    logic [LEN_W-1:0]   shamt;
    logic [DATA_W-1:0]  aligned;
    logic               last_bit;
    logic               load;

    // Left-align the word so the first bit to send always sits in the MSB.
    assign len_eff  = (in_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : in_len;
    assign shamt    = LEN_W'(DATA_W) - len_eff;
    assign aligned  = in_data << shamt;

    assign last_bit = (state == ST_SHIFT) && (bits_left == LEN_W'(1));
    assign in_ready = (state == ST_IDLE) || ((GAP == 0) && last_bit);
    assign busy     = (state != ST_IDLE);
    assign load     = in_valid && in_ready && (len_eff != '0);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            sr        <= '0;
            bits_left <= '0;
            gap_cnt   <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
        end else if (load) begin
            state     <= ST_SHIFT;
            out       <= aligned[DATA_W-1];
            out_valid <= 1'b1;
            sr        <= aligned << 1;
            bits_left <= len_eff;
        end else begin
            case (state)
                ST_IDLE: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                end
                ST_SHIFT: begin
                    if (!last_bit) begin
                        out       <= sr[DATA_W-1];
                        sr        <= sr << 1;
                        bits_left <= bits_left - 1'b1;
                    end else begin
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        bits_left <= '0;
                        if (GAP > 0) begin
                            state   <= ST_GAP;
                            gap_cnt <= GAP_W'(GAP - 1);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_match (
        .clk    (clk),
        .rstn   (rstn),
        .serial (out),
        .clr    (clr_cnt),
        .pulse  (match_pulse),
        .count  (match_cnt)
    );

endmodule
